board_renderer: RTL and testbench

BOARD_RENDERER -- requirements
Module: board_renderer

---
 rtl/board_renderer_pkg.sv | 35 +++
 rtl/board_cell_mapper.sv | 34 +++
 rtl/board_renderer.sv | 123 ++++++++++++
 tb/tb_board_renderer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/board_renderer_pkg.sv
// Shared types and constants for the board renderer: FSM states, sprite
// select codes, board cell codes and tile geometry.
package board_renderer_pkg;

  localparam int TILE_SIZE = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_DRAW,
    ST_GAP,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    SEL_EMPTY  = 2'd0,
    SEL_BLACK  = 2'd1,
    SEL_CURSOR = 2'd2,
    SEL_WHITE  = 2'd3
  } sel_t;

  typedef enum logic [1:0] {
    CELL_EMPTY    = 2'b00,
    CELL_BLACK    = 2'b01,
    CELL_WHITE    = 2'b10,
    CELL_RESERVED = 2'b11
  } cell_t;

  // v * TILE_SIZE as (v << 3) + (v << 2); max 7*12 = 84 fits in 7 bits.
  function automatic logic [6:0] times_tile(input logic [2:0] v);
    return {1'b0, v, 3'b000} + {2'b00, v, 2'b00};
  endfunction

endpackage

// File: rtl/board_cell_mapper.sv
// Combinational mapping of a board index and its cell contents to the tile
// origin and sprite code, with the captured cursor overriding the sprite.
module board_cell_mapper
  import board_renderer_pkg::*;
#(
  parameter int ORIGIN_X = 32,
  parameter int ORIGIN_Y = 12
) (
  input  logic [5:0] index,
  input  logic [1:0] cell_state,
  input  logic [2:0] cursor_row,
  input  logic [2:0] cursor_col,
  input  logic       cursor_en,
  output logic [7:0] tile_x,
  output logic [6:0] tile_y,
  output sel_t       tile_select
);

  localparam logic [7:0] OX = 8'(ORIGIN_X);
  localparam logic [6:0] OY = 7'(ORIGIN_Y);

  always_comb begin
    tile_x = OX + {1'b0, times_tile(index[2:0])};
    tile_y = OY + times_tile(index[5:3]);
    case (cell_t'(cell_state))
      CELL_BLACK: tile_select = SEL_BLACK;
      CELL_WHITE: tile_select = SEL_WHITE;
      default:    tile_select = SEL_EMPTY;
    endcase
    if (cursor_en && (index == {cursor_row, cursor_col}))
      tile_select = SEL_CURSOR;
  end

endmodule

// File: rtl/board_renderer.sv
// Walks the 8x8 board in row-major order, reading each cell and driving the
// plot helper with one tile_enable pulse per tile, then pulses done.
module board_renderer
  import board_renderer_pkg::*;
#(
  parameter int ORIGIN_X    = 32,
  parameter int ORIGIN_Y    = 12,
  parameter int TILE_CYCLES = 150,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] cursor_row,
  input  logic [2:0] cursor_col,
  input  logic       cursor_en,
  output logic [5:0] cell_addr,
  input  logic [1:0] cell_state,
  output logic [7:0] tile_x,
  output logic [6:0] tile_y,
  output logic [1:0] tile_select,
  output logic       tile_enable,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] TILE_LAST = 8'(TILE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  state_t     state;
  logic [5:0] index;
  logic [7:0] cnt;
  logic [2:0] cur_row_q;
  logic [2:0] cur_col_q;
  logic       cur_en_q;
  sel_t       sel_q;

  logic [7:0] map_x;
  logic [6:0] map_y;
  sel_t       map_sel;

  board_cell_mapper #(
    .ORIGIN_X(ORIGIN_X),
    .ORIGIN_Y(ORIGIN_Y)
  ) u_mapper (
    .index      (index),
    .cell_state (cell_state),
    .cursor_row (cur_row_q),
    .cursor_col (cur_col_q),
    .cursor_en  (cur_en_q),
    .tile_x     (map_x),
    .tile_y     (map_y),
    .tile_select(map_sel)
  );

  // The read address is the index itself, so it stays put from FETCH to GAP.
  assign cell_addr   = index;
  assign tile_select = sel_q;

  always_ff @(posedge clock) begin
    if (resetn) begin
      state       <= ST_IDLE;
      index       <= '0;
      cnt         <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      cur_en_q    <= 1'b0;
      tile_x      <= '0;
      tile_y      <= '0;
      sel_q       <= SEL_EMPTY;
      tile_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            index     <= '0;
            busy      <= 1'b1;
            cur_row_q <= cursor_row;
            cur_col_q <= cursor_col;
            cur_en_q  <= cursor_en;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          tile_x      <= map_x;
          tile_y      <= map_y;
          sel_q       <= map_sel;
          tile_enable <= 1'b1;
          cnt         <= TILE_LAST;
          state       <= ST_DRAW;
        end
        ST_DRAW: begin
          if (cnt == '0) begin
            tile_enable <= 1'b0;
            cnt         <= GAP_LAST;
            state       <= ST_GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else if (index == 6'd63) begin
            state <= ST_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            index <= index + 6'd1;
            state <= ST_FETCH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: directed table, randomized boards
// against a tile-list reference model, and reset/start corner sequences.
module tb_board_renderer;

  localparam int OX = 32;
  localparam int OY = 12;
  localparam int TC = 150;
  localparam int GC = 2;
  localparam int PERIOD = 2 + TC + GC;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [2:0] cursor_row;
  logic [2:0] cursor_col;
  logic       cursor_en;
  logic [5:0] cell_addr;
  logic [1:0] cell_state;
  logic [7:0] tile_x;
  logic [6:0] tile_y;
  logic [1:0] tile_select;
  logic       tile_enable;
  logic       busy;
  logic       done;

  board_renderer #(
    .ORIGIN_X(OX),
    .ORIGIN_Y(OY),
    .TILE_CYCLES(TC),
    .GAP_CYCLES(GC)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .cursor_en  (cursor_en),
    .cell_addr  (cell_addr),
    .cell_state (cell_state),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .tile_select(tile_select),
    .tile_enable(tile_enable),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Board memory: registered read, data one cycle after the address.
  logic [1:0] mem [64];
  always @(posedge clock) cell_state <= mem[cell_addr];

  int edges = 0;
  always @(posedge clock) edges <= edges + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Tile monitor
  bit         mon_on = 0;
  bit         prev_en = 0;
  int         rises, hi_cur, done_cnt, unstable;
  logic [7:0] rx [64];
  logic [6:0] ry [64];
  logic [1:0] rs [64];
  int         rt [64];
  int         hi_len [64];
  logic [16:0] last_tile;

  always @(negedge clock) begin
    if (mon_on) begin
      if (tile_enable && !prev_en) begin
        if (rises < 64) begin
          rx[rises] = tile_x;
          ry[rises] = tile_y;
          rs[rises] = tile_select;
          rt[rises] = edges;
        end
        rises++;
        hi_cur = 0;
      end
      if (tile_enable) begin
        hi_cur++;
        if (prev_en && ({tile_x, tile_y, tile_select} != last_tile)) unstable++;
      end
      if (!tile_enable && prev_en && rises >= 1 && rises <= 64) hi_len[rises-1] = hi_cur;
      if (done) done_cnt++;
    end
    last_tile = {tile_x, tile_y, tile_select};
    prev_en = tile_enable;
  end

  function automatic logic [16:0] model_tile(input int i, input int cr, input int cc, input bit ce);
    int x, y, sel;
    x = (OX + (i % 8) * 12) % 256;
    y = (OY + (i / 8) * 12) % 128;
    case (mem[i])
      2'b01:   sel = 1;
      2'b10:   sel = 3;
      default: sel = 0;
    endcase
    if (ce && i == cr * 8 + cc) sel = 2;
    return {x[7:0], y[6:0], sel[1:0]};
  endfunction

  task automatic run_frame(input int cr, input int cc, input bit ce,
                           input bit disturb, input bit start_at_finish);
    int s;
    int budget;
    cursor_row = 3'(cr);
    cursor_col = 3'(cc);
    cursor_en  = ce;
    rises = 0; done_cnt = 0; unstable = 0; hi_cur = 0;
    for (int i = 0; i < 64; i++) begin rt[i] = 0; hi_len[i] = 0; end
    mon_on = 1;
    start = 1'b1;
    s = edges;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (disturb) begin
      cursor_row = ~cursor_row;
      cursor_col = ~cursor_col;
      cursor_en  = ~cursor_en;
      repeat (700) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    budget = 0;
    while (!done && budget < 12000) begin
      @(negedge clock);
      budget++;
    end
    if (!done) chk("done_timeout", 0, 1);
    chk("done_cycle", edges - s, 1 + 64 * PERIOD);
    chk("busy_at_done", busy, 0);
    if (start_at_finish) start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_finish", busy, 0);
    repeat (6) @(negedge clock);
    chk("idle_quiet_busy", busy, 0);
    chk("tile_count", rises, 64);
    chk("done_count", done_cnt, 1);
    chk("tile_stable", unstable, 0);
    chk("first_enable_cycle", rt[0] - s, 3);
    mon_on = 0;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("tile%0d", i), {rx[i], ry[i], rs[i]}, model_tile(i, cr, cc, ce));
      chk($sformatf("high_len%0d", i), hi_len[i], TC);
      if (i < 63) begin
        chk($sformatf("period%0d", i), rt[i+1] - rt[i], PERIOD);
        chk($sformatf("low_len%0d", i), rt[i+1] - rt[i] - hi_len[i], PERIOD - TC);
      end
    end
  endtask

  typedef struct {
    int         idx;
    logic [1:0] val;
    int         ex;
    int         ey;
    int         esel;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int s;
    int ndone;
    vecs[0] = '{idx: 0,  val: 2'b00, ex: 32,  ey: 12, esel: 0};
    vecs[1] = '{idx: 9,  val: 2'b01, ex: 44,  ey: 24, esel: 1};
    vecs[2] = '{idx: 63, val: 2'b10, ex: 116, ey: 96, esel: 3};
    vecs[3] = '{idx: 10, val: 2'b11, ex: 56,  ey: 24, esel: 0};
    vecs[4] = '{idx: 21, val: 2'b01, ex: 92,  ey: 36, esel: 2};
    vecs[5] = '{idx: 7,  val: 2'b10, ex: 116, ey: 12, esel: 3};

    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    resetn = 1'b1;
    start = 1'b1;
    cursor_row = '0; cursor_col = '0; cursor_en = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_busy_with_start", busy, 0);
    start = 1'b0;
    resetn = 1'b0;
    chk("reset_cell_addr", cell_addr, 0);
    chk("reset_tile_x", tile_x, 0);
    chk("reset_tile_y", tile_y, 0);
    chk("reset_select", tile_select, 0);
    chk("reset_enable", tile_enable, 0);
    chk("reset_done", done, 0);
    @(negedge clock);
    chk("idle_busy", busy, 0);

    // Empty board, no cursor
    run_frame(0, 0, 1'b0, 1'b0, 1'b0);

    // Directed cells, cursor (2,5) over black; cursor moved and start re-pulsed mid-frame
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    foreach (vecs[k]) mem[vecs[k].idx] = vecs[k].val;
    run_frame(2, 5, 1'b1, 1'b1, 1'b0);
    foreach (vecs[k])
      chk($sformatf("vec_tile%0d", vecs[k].idx), {rx[vecs[k].idx], ry[vecs[k].idx], rs[vecs[k].idx]},
          {8'(vecs[k].ex), 7'(vecs[k].ey), 2'(vecs[k].esel)});

    // Random board, start coincident with FINISH
    for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
    run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b1);

    // Reset during DRAW of tile 3
    for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
    start = 1'b1;
    s = edges;
    @(negedge clock);
    start = 1'b0;
    while (edges < s + 500) @(negedge clock);
    chk("enable_before_reset", tile_enable, 1);
    resetn = 1'b1;
    @(negedge clock);
    resetn = 1'b0;
    chk("reset_mid_enable", tile_enable, 0);
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_done", done, 0);
    chk("reset_mid_addr", cell_addr, 0);
    ndone = 0;
    repeat (30) begin
      @(negedge clock);
      if (done || busy || tile_enable) ndone++;
    end
    chk("quiet_after_reset", ndone, 0);

    // New start after reset redraws from index 0
    run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
